// File: rtl/adc128s022_sampler.sv
// Periodic SPI master for the ADC128S022: fixed-channel frames at a programmable rate, 8-bit result.
// Optional feature macro: ADC128S022_SAMPLER_AVG_EN (average 4 committed results per output).
module adc128s022_sampler #(
  parameter int unsigned CLK_DIV       = 8,
  parameter int unsigned CHANNEL       = 0,
  parameter int unsigned SAMPLE_PERIOD = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned HALF_W = 5;
  localparam int unsigned RX_W   = 12;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(31);
  localparam logic [15:0]       CTRL_WORD = {2'b00, 3'(CHANNEL), 11'd0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [PER_W-1:0]    period_q, period_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [15:0]         tx_q, tx_d;
  logic [RX_W-1:0]     rx_q, rx_d;
  logic                primed_q, primed_d;
  logic                en_q, en_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                din_q, din_d;
  logic [7:0]          sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                start_tick;
`ifdef ADC128S022_SAMPLER_AVG_EN
  logic [13:0]         acc_q, acc_d;
  logic [1:0]          acc_cnt_q, acc_cnt_d;
  logic [13:0]         acc_sum;
`endif

  // Next-state logic: period counter, frame sequencer, capture and commit.
  // rx_q keeps only the last 12 bits shifted in; the 4 leading DOUT bits fall off the top.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    div_d      = div_q;
    half_d     = half_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    primed_d   = primed_q;
    en_d       = enable;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    din_d      = din_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    start_tick = 1'b0;
`ifdef ADC128S022_SAMPLER_AVG_EN
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    acc_sum    = acc_q + 14'(rx_q);
`endif

    if (!enable) begin
      period_d = '0;
    end else begin
      start_tick = (period_q == '0);
      period_d   = (period_q == PER_LAST) ? '0 : period_q + PER_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_tick) begin
          state_d = ST_CS_SETUP;
          div_d   = '0;
          tx_d    = CTRL_WORD;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
          din_d   = tx_q[15];
          tx_d    = {tx_q[14:0], 1'b0};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (half_q == HALF_LAST) begin
            state_d = ST_CS_HOLD;
            sclk_d  = 1'b1;
            din_d   = 1'b0;
          end else begin
            half_d = half_q + HALF_W'(1);
            if (half_q[0]) begin
              // High phase ends: falling SCLK, present the next address bit.
              sclk_d = 1'b0;
              din_d  = tx_q[15];
              tx_d   = {tx_q[14:0], 1'b0};
            end else begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[RX_W-2:0], adc_dout};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_CS_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d  = ST_IDLE;
          div_d    = '0;
          cs_n_d   = 1'b1;
          busy_d   = 1'b0;
          primed_d = 1'b1;
          // The ADC returns the previously addressed channel, so the first frame is dropped.
          if (primed_q) begin
`ifdef ADC128S022_SAMPLER_AVG_EN
            if (acc_cnt_q == 2'd3) begin
              sample_d  = acc_sum[13:6];
              valid_d   = 1'b1;
              acc_d     = '0;
              acc_cnt_d = '0;
            end else begin
              acc_d     = acc_sum;
              acc_cnt_d = acc_cnt_q + 2'd1;
            end
`else
            sample_d = rx_q[11:4];
            valid_d  = 1'b1;
`endif
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enable && !en_q) begin
      primed_d = 1'b0;
`ifdef ADC128S022_SAMPLER_AVG_EN
      acc_d     = '0;
      acc_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      div_q     <= '0;
      half_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      primed_q  <= 1'b0;
      en_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ADC128S022_SAMPLER_AVG_EN
      acc_q     <= '0;
      acc_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      div_q     <= div_d;
      half_q    <= half_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      primed_q  <= primed_d;
      en_q      <= en_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef ADC128S022_SAMPLER_AVG_EN
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
`endif
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc128s022_sampler.sv
// Self-checking bench for adc128s022_sampler: ADC model, frame monitor and a frame-level reference model.
module tb_adc128s022_sampler;

  localparam int unsigned CH = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_din;
  logic       adc_dout = 1'b0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       busy;

  int checks = 0;
  int failures = 0;

  adc128s022_sampler #(.CLK_DIV(2), .CHANNEL(CH), .SAMPLE_PERIOD(100)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // ADC model: shifts the queued 16-bit word out MSB first, changing DOUT on SCLK falling edges.
  logic [15:0] word_q[$];
  logic [15:0] cur_word = 16'h0000;
  logic [15:0] din_cap = 16'h0000;
  logic [15:0] frame_din = 16'h0000;
  int          sclk_rises = 0;
  int          frame_rises = 0;

  always @(negedge adc_cs_n) begin
    cur_word   = (word_q.size() > 0) ? word_q.pop_front() : 16'h0000;
    sclk_rises = 0;
    din_cap    = 16'h0000;
    adc_dout   = cur_word[15];
  end
  always @(negedge adc_sclk) if (!adc_cs_n && sclk_rises < 16) adc_dout = cur_word[15 - sclk_rises];
  always @(posedge adc_sclk) if (!adc_cs_n) begin
    din_cap = {din_cap[14:0], adc_din};
    sclk_rises++;
  end
  always @(posedge adc_cs_n) begin
    frame_din   = din_cap;
    frame_rises = sclk_rises;
  end

  // Cycle-sampled monitor of chip-select timing and result pulses.
  int         cyc = 0, fall_cnt = 0, rise_cnt = 0, valid_cnt = 0;
  int         fall_gap = 0, low_len = 0, last_fall_cyc = 0, valid_run = 0, max_valid_run = 0;
  logic       cs_prev = 1'b1;
  logic [7:0] last_sample = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (cs_prev && !adc_cs_n) begin
      fall_gap      = cyc - last_fall_cyc;
      last_fall_cyc = cyc;
      fall_cnt++;
    end
    if (!cs_prev && adc_cs_n) begin
      low_len = cyc - last_fall_cyc;
      rise_cnt++;
    end
    cs_prev = adc_cs_n;
    if (sample_valid) begin
      valid_cnt++;
      last_sample = sample;
      valid_run++;
      if (valid_run > max_valid_run) max_valid_run = valid_run;
    end else begin
      valid_run = 0;
    end
  end

  // Reference model at frame granularity: discard after restart, then commit or average.
  bit m_primed = 1'b0;
  int m_acc = 0;
  int m_n = 0;

  task automatic model_restart();
    m_primed = 1'b0;
    m_acc    = 0;
    m_n      = 0;
  endtask

  task automatic model_frame(input logic [15:0] w, output bit pulse, output logic [7:0] val);
    int r;
    r     = int'(w[11:0]);
    pulse = 1'b0;
    val   = 8'h00;
    if (!m_primed) begin
      m_primed = 1'b1;
      return;
    end
`ifdef ADC128S022_SAMPLER_AVG_EN
    m_acc += r;
    m_n++;
    if (m_n == 4) begin
      pulse = 1'b1;
      val   = 8'(m_acc / 64);
      m_acc = 0;
      m_n   = 0;
    end
`else
    pulse = 1'b1;
    val   = 8'(r / 16);
`endif
  endtask

  task automatic wait_rise(input int r0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (rise_cnt > r0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fall(input int f0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (fall_cnt > f0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    enable  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk: got %b expected 1", adc_sclk); end
    checks++; if (adc_din !== 1'b0) begin failures++; $display("FAIL reset_din: got %b expected 0", adc_din); end
    checks++; if (sample !== 8'h00) begin failures++; $display("FAIL reset_sample: got %h expected 00", sample); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_restart();
    repeat (150) @(posedge clk);
    #1;
    checks++; if (fall_cnt !== 0) begin failures++; $display("FAIL idle_no_frames: got %0d cs_n falls expected 0", fall_cnt); end
  endtask

  task automatic test_basic();
    logic [15:0] w[2];
    bit ok, pulse;
    logic [7:0] val;
    int v0, r0;
    for (int i = 0; i < 2; i++) begin
      w[i] = {4'($urandom), 12'hABC};
      word_q.push_back(w[i]);
    end
    model_restart();
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v0 = valid_cnt; r0 = rise_cnt;
      wait_rise(r0, ok);
      repeat (2) @(posedge clk); #1;
      model_frame(w[i], pulse, val);
      checks++;
      if (!ok || (valid_cnt - v0) !== int'(pulse)) begin
        failures++; $display("FAIL basic_pulse frame %0d: got %0d pulses expected %0d (ok=%0d)", i, valid_cnt - v0, int'(pulse), ok);
      end
      if (pulse) begin
        checks++; if (last_sample !== val) begin failures++; $display("FAIL basic_sample frame %0d: got %h expected %h", i, last_sample, val); end
      end
    end
    checks++; if (fall_gap !== 100) begin failures++; $display("FAIL basic_period: got %0d cycles expected 100", fall_gap); end
    checks++; if (low_len !== 68) begin failures++; $display("FAIL basic_frame_len: got %0d cycles expected 68", low_len); end
  endtask

  task automatic test_address();
    logic [15:0] w[2];
    logic [15:0] exp_din;
    bit ok, pulse;
    logic [7:0] val;
    int v0, r0;
    exp_din = 16'(CH << 11);
    for (int i = 0; i < 2; i++) begin
      w[i] = 16'($urandom);
      word_q.push_back(w[i]);
    end
    for (int i = 0; i < 2; i++) begin
      v0 = valid_cnt; r0 = rise_cnt;
      wait_rise(r0, ok);
      repeat (2) @(posedge clk); #1;
      model_frame(w[i], pulse, val);
      checks++; if (!ok || frame_din !== exp_din) begin failures++; $display("FAIL addr_din frame %0d: got %h expected %h", i, frame_din, exp_din); end
      checks++; if (frame_rises !== 16) begin failures++; $display("FAIL addr_sclk_rises frame %0d: got %0d expected 16", i, frame_rises); end
      checks++; if (low_len !== 68) begin failures++; $display("FAIL addr_cs_low frame %0d: got %0d expected 68", i, low_len); end
      checks++;
      if ((valid_cnt - v0) !== int'(pulse)) begin failures++; $display("FAIL addr_pulse frame %0d: got %0d expected %0d", i, valid_cnt - v0, int'(pulse)); end
      if (pulse) begin
        checks++; if (last_sample !== val) begin failures++; $display("FAIL addr_sample frame %0d: got %h expected %h", i, last_sample, val); end
      end
    end
  endtask

  task automatic test_random_data();
    logic [15:0] w[8];
    bit ok, pulse;
    logic [7:0] val;
    int v0, r0;
    for (int i = 0; i < 8; i++) begin
      w[i] = 16'($urandom);
      word_q.push_back(w[i]);
    end
    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt; r0 = rise_cnt;
      wait_rise(r0, ok);
      repeat (2) @(posedge clk); #1;
      model_frame(w[i], pulse, val);
      checks++;
      if (!ok || (valid_cnt - v0) !== int'(pulse)) begin failures++; $display("FAIL rand_pulse frame %0d: got %0d expected %0d", i, valid_cnt - v0, int'(pulse)); end
      if (pulse) begin
        checks++; if (last_sample !== val) begin failures++; $display("FAIL rand_sample frame %0d word %h: got %h expected %h", i, w[i], last_sample, val); end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [15:0] w[3];
    bit ok, pulse;
    logic [7:0] val;
    int v0, r0, f0, f1, r1;
    for (int i = 0; i < 3; i++) w[i] = {4'($urandom), 12'h5A5 ^ 12'($urandom_range(0, 15))};
    word_q.push_back(w[0]);
    f0 = fall_cnt; v0 = valid_cnt; r0 = rise_cnt;
    wait_fall(f0, ok);
    repeat (20) @(posedge clk);
    #1 enable = 1'b0;
    wait_rise(r0, ok);
    repeat (2) @(posedge clk); #1;
    model_frame(w[0], pulse, val);
    checks++;
    if (!ok || (valid_cnt - v0) !== int'(pulse)) begin failures++; $display("FAIL drop_commit: got %0d pulses expected %0d", valid_cnt - v0, int'(pulse)); end
    if (pulse) begin
      checks++; if (last_sample !== val) begin failures++; $display("FAIL drop_sample: got %h expected %h", last_sample, val); end
    end
    f1 = fall_cnt; r1 = rise_cnt;
    repeat (300) @(posedge clk); #1;
    checks++; if (fall_cnt !== f1 || rise_cnt !== r1) begin failures++; $display("FAIL drop_quiet: got %0d extra cs_n edges expected 0", (fall_cnt - f1) + (rise_cnt - r1)); end
    checks++; if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin failures++; $display("FAIL drop_idle: got busy=%b cs_n=%b expected busy=0 cs_n=1", busy, adc_cs_n); end
    word_q.push_back(w[1]);
    word_q.push_back(w[2]);
    model_restart();
    enable = 1'b1;
    for (int i = 1; i < 3; i++) begin
      v0 = valid_cnt; r0 = rise_cnt;
      wait_rise(r0, ok);
      repeat (2) @(posedge clk); #1;
      model_frame(w[i], pulse, val);
      checks++;
      if (!ok || (valid_cnt - v0) !== int'(pulse)) begin failures++; $display("FAIL reenable_pulse frame %0d: got %0d expected %0d", i, valid_cnt - v0, int'(pulse)); end
      if (pulse) begin
        checks++; if (last_sample !== val) begin failures++; $display("FAIL reenable_sample frame %0d: got %h expected %h", i, last_sample, val); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[2];
    bit ok, pulse;
    logic [7:0] val;
    int v0, r0, f0;
    word_q.push_back(16'($urandom));
    f0 = fall_cnt;
    wait_fall(f0, ok);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (!ok || adc_cs_n !== 1'b1) begin failures++; $display("FAIL midreset_cs_n: got %b expected 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin failures++; $display("FAIL midreset_sclk: got %b expected 1", adc_sclk); end
    checks++; if (sample !== 8'h00) begin failures++; $display("FAIL midreset_sample: got %h expected 00", sample); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (adc_din !== 1'b0) begin failures++; $display("FAIL midreset_din: got %b expected 0", adc_din); end
    for (int i = 0; i < 2; i++) begin
      w[i] = 16'($urandom);
      word_q.push_back(w[i]);
    end
    repeat (3) @(posedge clk);
    model_restart();
    r0 = rise_cnt;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v0 = valid_cnt;
      wait_rise(r0, ok);
      r0 = rise_cnt;
      repeat (2) @(posedge clk); #1;
      model_frame(w[i], pulse, val);
      checks++;
      if (!ok || (valid_cnt - v0) !== int'(pulse)) begin failures++; $display("FAIL postreset_pulse frame %0d: got %0d expected %0d", i, valid_cnt - v0, int'(pulse)); end
      if (pulse) begin
        checks++; if (last_sample !== val) begin failures++; $display("FAIL postreset_sample frame %0d: got %h expected %h", i, last_sample, val); end
      end
    end
  endtask

  task automatic test_averaging();
    logic [15:0] w[5];
    bit ok, pulse;
    logic [7:0] val;
    int v0, r0;
    w[0] = 16'($urandom);
    w[1] = {4'($urandom), 12'h100};
    w[2] = {4'($urandom), 12'h104};
    w[3] = {4'($urandom), 12'h108};
    w[4] = {4'($urandom), 12'h10C};
    enable = 1'b0;
    repeat (5) @(posedge clk);
    for (int i = 0; i < 5; i++) word_q.push_back(w[i]);
    model_restart();
    #1 enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt; r0 = rise_cnt;
      wait_rise(r0, ok);
      repeat (2) @(posedge clk); #1;
      model_frame(w[i], pulse, val);
      checks++;
      if (!ok || (valid_cnt - v0) !== int'(pulse)) begin failures++; $display("FAIL avg_pulse frame %0d: got %0d expected %0d", i, valid_cnt - v0, int'(pulse)); end
      if (pulse) begin
        checks++; if (last_sample !== val) begin failures++; $display("FAIL avg_sample frame %0d: got %h expected %h", i, last_sample, val); end
      end
    end
  endtask

  task automatic test_boundary();
`ifdef ADC128S022_SAMPLER_AVG_EN
    localparam int REPS = 4;
`else
    localparam int REPS = 1;
`endif
    logic [15:0] w[2*REPS];
    bit ok, pulse;
    logic [7:0] val;
    int v0, r0;
    for (int i = 0; i < 2 * REPS; i++) begin
      w[i] = (i < REPS) ? 16'hFFFF : 16'hF000;
      word_q.push_back(w[i]);
    end
    for (int i = 0; i < 2 * REPS; i++) begin
      v0 = valid_cnt; r0 = rise_cnt;
      wait_rise(r0, ok);
      repeat (2) @(posedge clk); #1;
      model_frame(w[i], pulse, val);
      checks++;
      if (!ok || (valid_cnt - v0) !== int'(pulse)) begin failures++; $display("FAIL bound_pulse frame %0d: got %0d expected %0d", i, valid_cnt - v0, int'(pulse)); end
      if (pulse) begin
        checks++; if (last_sample !== val) begin failures++; $display("FAIL bound_sample frame %0d word %h: got %h expected %h", i, w[i], last_sample, val); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_address();
    test_random_data();
    test_enable_drop();
    test_reset_mid();
    test_averaging();
    test_boundary();
    checks++; if (max_valid_run !== 1) begin failures++; $display("FAIL valid_width: got %0d cycles expected 1", max_valid_run); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
